ge_precomp_select: RTL and testbench

Constant-time selection of one precomputed Ed25519 point, in (y+x, y−x, 2dxy) form, from an 8-entry table, driven by a signed radix-16 scalar digit b in [−8, 8]. The block scans all eight entries and conditionally moves each one using the per-digit equality test. It then conditionally negates the result. The block sits between the scalar-digit recoder and the fixed-base point adder. Cycle count and table access pattern are independent of b.

---
 rtl/ge_precomp_select.sv | 135 +++++++++++++
 tb/tb_ge_precomp_select.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ge_precomp_select.sv
// Constant-time selection of one precomputed Ed25519 point (y+x, y-x, 2dxy) from an
// 8-entry table by a signed radix-16 digit, with conditional negation of the result.
module ge_precomp_select #(
  parameter int unsigned FE_W      = 255,
  parameter int unsigned N_ENTRIES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        digit,
  output logic              busy,
  output logic              done,
  output logic              tbl_rd_en,
  output logic [2:0]        tbl_addr,
  input  logic [3*FE_W-1:0] tbl_data,
  output logic [FE_W-1:0]   out_yplusx,
  output logic [FE_W-1:0]   out_yminusx,
  output logic [FE_W-1:0]   out_xy2d
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINAL} state_t;

  // p = 2^255 - 19
  localparam logic [FE_W-1:0] P = {{(FE_W-5){1'b1}}, 5'b01101};

  state_t          state_q;
  logic            neg_q;
  logic [7:0]      babs_q;
  logic [2:0]      idx_q;
  logic [FE_W-1:0] acc_pp_q, acc_pm_q, acc_xy_q;
  logic            busy_q, done_q, rd_en_q;
  logic [2:0]      addr_q;
  logic [FE_W-1:0] out_pp_q, out_pm_q, out_xy_q;

  logic [7:0]      babs_d;
  logic [7:0]      idx_p1;
  logic [31:0]     diff, diff_m1;
  logic            eq;
  logic [FE_W-1:0] m, mn, nzm, negx;
  logic [FE_W-1:0] acc_pp_d, acc_pm_d, acc_xy_d;
  logic [FE_W-1:0] out_pp_d, out_pm_d, out_xy_d;
  logic            acc_en;

  always_comb begin
    babs_d  = digit - (({8{digit[7]}} & digit) << 1);
    idx_p1  = {5'b0, idx_q} + 8'd1;
    // Equality without a comparator branch: (x ^ y) - 1 underflows into bit 31 only when x == y.
    diff    = {24'b0, babs_q ^ idx_p1};
    diff_m1 = diff - 32'd1;
    eq      = diff_m1[31];
    m       = {FE_W{eq}};
    acc_pp_d = (acc_pp_q & ~m) | (tbl_data[3*FE_W-1:2*FE_W] & m);
    acc_pm_d = (acc_pm_q & ~m) | (tbl_data[2*FE_W-1:FE_W]   & m);
    acc_xy_d = (acc_xy_q & ~m) | (tbl_data[FE_W-1:0]        & m);
    acc_en   = ((state_q == FETCH) && (addr_q != '0)) || (state_q == DRAIN);

    // Negation always computed; zero input maps to zero rather than p.
    nzm      = {FE_W{|acc_xy_q}};
    negx     = (P - acc_xy_q) & nzm;
    mn       = {FE_W{neg_q}};
    out_pp_d = (acc_pp_q & ~mn) | (acc_pm_q & mn);
    out_pm_d = (acc_pm_q & ~mn) | (acc_pp_q & mn);
    out_xy_d = (acc_xy_q & ~mn) | (negx & mn);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      neg_q    <= 1'b0;
      babs_q   <= '0;
      idx_q    <= '0;
      acc_pp_q <= '0;
      acc_pm_q <= '0;
      acc_xy_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      out_pp_q <= '0;
      out_pm_q <= '0;
      out_xy_q <= '0;
    end else begin
      done_q <= 1'b0;
      idx_q  <= addr_q;
      if (acc_en) begin
        acc_pp_q <= acc_pp_d;
        acc_pm_q <= acc_pm_d;
        acc_xy_q <= acc_xy_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= FETCH;
            neg_q    <= digit[7];
            babs_q   <= babs_d;
            acc_pp_q <= {{(FE_W-1){1'b0}}, 1'b1};
            acc_pm_q <= {{(FE_W-1){1'b0}}, 1'b1};
            acc_xy_q <= '0;
            busy_q   <= 1'b1;
            rd_en_q  <= 1'b1;
            addr_q   <= '0;
          end
        end
        FETCH: begin
          if (addr_q == 3'(N_ENTRIES - 1)) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
          end else begin
            addr_q <= addr_q + 3'd1;
          end
        end
        DRAIN: state_q <= FINAL;
        FINAL: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          out_pp_q <= out_pp_d;
          out_pm_q <= out_pm_d;
          out_xy_q <= out_xy_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign tbl_rd_en   = rd_en_q;
  assign tbl_addr    = addr_q;
  assign out_yplusx  = out_pp_q;
  assign out_yminusx = out_pm_q;
  assign out_xy2d    = out_xy_q;

endmodule

// File: tb/tb_ge_precomp_select.sv
// Directed bench for ge_precomp_select: table model, per-operation control trace and result checks.
module tb_ge_precomp_select;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [7:0]   digit;
  logic         busy, done, tbl_rd_en;
  logic [2:0]   tbl_addr;
  logic [764:0] tbl_data;
  logic [254:0] out_yplusx, out_yminusx, out_xy2d;

  int checks = 0;
  int errors = 0;

  logic [255:0] pfull;
  logic [254:0] P;
  logic [764:0] mem [8];

  logic [254:0] A, B, C;

  ge_precomp_select #(.FE_W(255), .N_ENTRIES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .digit(digit),
    .busy(busy), .done(done), .tbl_rd_en(tbl_rd_en), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .out_yplusx(out_yplusx), .out_yminusx(out_yminusx), .out_xy2d(out_xy2d)
  );

  always #5 clk = ~clk;

  // Table memory: one-cycle read latency; junk when not reading
  always @(posedge clk) begin
    if (tbl_rd_en) tbl_data <= mem[tbl_addr];
    else           tbl_data <= {765{1'b1}};
  end

  task automatic chk(input string tag, input logic [254:0] obs, input logic [254:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [254:0] rfe();
    logic [255:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return {1'b0, t[253:0]};
  endfunction

  task automatic fill_table();
    for (int i = 0; i < 8; i++) mem[i] = {rfe(), rfe(), rfe()};
  endtask

  task automatic expect_for(input int b, output logic [254:0] e_pp, output logic [254:0] e_pm,
                            output logic [254:0] e_xy);
    logic [254:0] a, bb, c;
    if (b >= 1 && b <= 8) begin
      {e_pp, e_pm, e_xy} = mem[b-1];
    end else if (b <= -1 && b >= -8) begin
      {a, bb, c} = mem[-b-1];
      e_pp = bb;
      e_pm = a;
      e_xy = (c == '0) ? '0 : P - c;
    end else begin
      e_pp = 255'd1;
      e_pm = 255'd1;
      e_xy = '0;
    end
  endtask

  // Called at a negedge; leaves at the negedge of cycle 11 (the done cycle).
  task automatic run_op(input int b, input bit extra_starts, input string tag);
    logic [65:0]  tr_obs, tr_exp;
    logic [254:0] e_pp, e_pm, e_xy;
    digit = 8'(b);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      tr_obs[(c-1)*6 +: 6] = {busy, done, tbl_rd_en, (c <= 8) ? tbl_addr : 3'd0};
      tr_exp[(c-1)*6 +: 6] = {(c <= 10) ? 1'b1 : 1'b0, (c == 11) ? 1'b1 : 1'b0,
                              (c <= 8) ? 1'b1 : 1'b0, (c <= 8) ? 3'(c-1) : 3'd0};
      if (extra_starts && (c == 3 || c == 10)) begin
        start = 1'b1;
        digit = 8'd5;
      end else begin
        start = 1'b0;
      end
      if (c < 11) @(negedge clk);
    end
    expect_for(b, e_pp, e_pm, e_xy);
    chk({tag, "_trace"}, {189'd0, tr_obs}, {189'd0, tr_exp});
    chk({tag, "_yplusx"}, out_yplusx, e_pp);
    chk({tag, "_yminusx"}, out_yminusx, e_pm);
    chk({tag, "_xy2d"}, out_xy2d, e_xy);
  endtask

  initial begin
    pfull = (256'd1 << 255) - 256'd19;
    P     = pfull[254:0];
    A = 255'h0123_4567_89ab_cdef_0011_2233_4455_6677_8899_aabb_ccdd_eeff_1357_9bdf_2468_ace0;
    B = 255'h2fed_cba9_8765_4321_ffee_ddcc_bbaa_9988_7766_5544_3322_1100_0f1e_2d3c_4b5a_6978;
    C = 255'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0001;

    rst = 1'b1; start = 1'b0; digit = '0;
    fill_table();
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("rst_ctl", {251'd0, busy, done, tbl_rd_en, tbl_addr}, '0);
    chk("rst_yplusx", out_yplusx, '0);
    chk("rst_yminusx", out_yminusx, '0);
    chk("rst_xy2d", out_xy2d, '0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    mem[2] = {A, B, C};
    run_op(3, 1'b0, "b3");
    chk("b3_direct_xy2d", out_xy2d, C);
    repeat (3) @(negedge clk);
    chk("hold_yplusx", out_yplusx, A);

    run_op(-3, 1'b0, "bm3");
    chk("bm3_direct_yplusx", out_yplusx, B);
    @(negedge clk);
    mem[2] = {A, B, 255'd0};
    run_op(-3, 1'b0, "bm3_c0");
    chk("bm3_c0_direct", out_xy2d, '0);

    @(negedge clk);
    run_op(0, 1'b0, "b0");
    run_op(9, 1'b0, "b9");
    run_op(-128, 1'b0, "bm128");
    run_op(8, 1'b0, "b8");
    run_op(-8, 1'b0, "bm8");

    @(negedge clk);
    mem[2] = {A, B, C};
    run_op(3, 1'b1, "ign");
    @(negedge clk);
    chk("ign_after", {253'd0, busy, done}, '0);

    run_op(5, 1'b0, "b2b_first");
    run_op(-5, 1'b0, "b2b_second");

    @(negedge clk);
    digit = 8'd3;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ctl", {252'd0, busy, done, tbl_rd_en}, '0);
    chk("abort_yplusx", out_yplusx, '0);
    chk("abort_yminusx", out_yminusx, '0);
    chk("abort_xy2d", out_xy2d, '0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_nodone", {253'd0, busy, done}, '0);
    end
    run_op(3, 1'b0, "post_rst");

    for (int b = -8; b <= 8; b++) begin
      @(negedge clk);
      fill_table();
      run_op(b, 1'b0, $sformatf("sweep%0d", b));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
